// File: rtl/seg7_capture_decoder.sv
// Purpose: recovers hex nibbles from a multiplexed active-low 7-segment bus, with strobe stability qualification.
// Latency: a capture lands on the (STABLE_CYCLES+1)th consecutive rising edge with identical pin values.
// Backpressure: none; this is a passive monitor that can never stall the display bus it observes.
//
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   seg_n         - segment lines, active-low (bit0=top ... bit6=middle)
//   digit_sel_n   - digit selects, active-low, one-hot when valid
//   clear         - synchronous clear of all captured state
//   value         - decoded nibbles, digit k at [4k+3:4k]
//   digit_valid   - digit k holds a legal or blank capture
//   digit_blank   - last capture of digit k was all segments off
//   digit_err     - last capture of digit k was an illegal pattern
//   frame_done    - one-cycle pulse once every digit has been captured
module seg7_capture_decoder #(
  parameter int NDIGITS       = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             seg_n,
  input  logic [NDIGITS-1:0]     digit_sel_n,
  input  logic                   clear,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     digit_valid,
  output logic [NDIGITS-1:0]     digit_blank,
  output logic [NDIGITS-1:0]     digit_err,
  output logic                   frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

  state_t              state, state_nxt;
  logic [NDIGITS-1:0]  s_sel, p_sel;
  logic [6:0]          s_seg, p_seg;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NDIGITS-1:0]  seen, seen_nxt;
  logic [NDIGITS-1:0]  sel_oh;
  logic                strobe_ok, same, capture, frame_hit;
  logic                dec_ok, is_blank;
  logic [3:0]          dec_nib;

  // Two-stage sampling: s_* is the current registered sample, p_* the one
  // before it, so the stability compare works purely on registered copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sel <= '1;
      s_seg <= 7'h7F;
      p_sel <= '1;
      p_seg <= 7'h7F;
    end else begin
      s_sel <= digit_sel_n;
      s_seg <= seg_n;
      p_sel <= s_sel;
      p_seg <= s_seg;
    end
  end

  always_comb begin
    sel_oh    = ~s_sel;
    strobe_ok = (sel_oh != '0) && ((sel_oh & (sel_oh - NDIGITS'(1))) == '0);
    same      = (s_sel == p_sel) && (s_seg == p_seg);
    if (same && strobe_ok)
      cnt_nxt = (cnt == CMAX) ? cnt : cnt + CW'(1);
    else
      cnt_nxt = strobe_ok ? CW'(1) : '0;
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (s_seg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
    is_blank = (s_seg == 7'h7F);
  end

  // Entry from IDLE checks the threshold too, so STABLE_CYCLES=1 captures
  // on the first valid sample. CAPTURED only re-arms on a sample change.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (strobe_ok) begin
          if (cnt_nxt == CMAX) begin
            capture   = 1'b1;
            state_nxt = CAPTURED;
          end else begin
            state_nxt = TRACK;
          end
        end
      end
      TRACK: begin
        if (!strobe_ok) begin
          state_nxt = IDLE;
        end else if (cnt_nxt == CMAX) begin
          capture   = 1'b1;
          state_nxt = CAPTURED;
        end
      end
      CAPTURED: begin
        if (!same) begin
          if (!strobe_ok) begin
            state_nxt = IDLE;
          end else if (cnt_nxt == CMAX) begin
            capture   = 1'b1;
            state_nxt = CAPTURED;
          end else begin
            state_nxt = TRACK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    seen_nxt  = seen | (capture ? sel_oh : '0);
    frame_hit = capture && (&seen_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      digit_valid <= '0;
      digit_blank <= '0;
      digit_err   <= '0;
      frame_done  <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      digit_valid <= '0;
      digit_blank <= '0;
      digit_err   <= '0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      frame_done <= frame_hit;
      seen       <= frame_hit ? '0 : seen_nxt;
      if (capture) begin
        for (int k = 0; k < NDIGITS; k++) begin
          if (sel_oh[k]) begin
            if (dec_ok) begin
              value[4*k +: 4] <= dec_nib;
              digit_valid[k]  <= 1'b1;
              digit_blank[k]  <= 1'b0;
              digit_err[k]    <= 1'b0;
            end else if (is_blank) begin
              digit_valid[k]  <= 1'b1;
              digit_blank[k]  <= 1'b1;
              digit_err[k]    <= 1'b0;
            end else begin
              digit_valid[k]  <= 1'b0;
              digit_blank[k]  <= 1'b0;
              digit_err[k]    <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Purpose: directed self-checking bench for seg7_capture_decoder.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Backpressure: not applicable; the bench drives the display bus freely.
module tb_seg7_capture_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [6:0]  seg_n;
  logic [7:0]  digit_sel_n;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic [7:0]  digit_blank;
  logic [7:0]  digit_err;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [6:0] segtab [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

  always #5 clk = ~clk;

  seg7_capture_decoder #(.NDIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .digit_sel_n (digit_sel_n),
    .clear       (clear),
    .value       (value),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 unit after each; counts frame_done pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) fd_cnt++;
    end
  endtask

  int  fd0;
  logic saw5;

  initial begin
    rst         = 1'b1;
    clear       = 1'b0;
    digit_sel_n = 8'hFF;
    seg_n       = 7'h7F;
    step(3);
    chk("rst_value", value, 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_blank", 32'(digit_blank), 32'h0);
    chk("rst_err",   32'(digit_err), 32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);

    // digit0 shows 3: nothing after 4 edges, captured on the 5th
    rst         = 1'b0;
    digit_sel_n = 8'hFE;
    seg_n       = 7'h30;
    step(4);
    chk("d0_val_e4",   value, 32'h0);
    chk("d0_vld_e4",   32'(digit_valid), 32'h0);
    step(1);
    chk("d0_val_e5",   value, 32'h3);
    chk("d0_vld_e5",   32'(digit_valid), 32'h01);
    step(3);
    chk("d0_hold",     value, 32'h3);

    // digit1: 5 shown briefly, then 6 held
    digit_sel_n = 8'hFD;
    seg_n       = 7'h12;
    saw5        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) seg_n = 7'h02;
      step(1);
      if (value[7:4] == 4'h5) saw5 = 1'b1;
      if (i == 6) chk("d1_before_cap", 32'(value[7:4]), 32'h0);
    end
    chk("d1_never5", 32'(saw5), 32'h0);
    chk("d1_val",    value, 32'h63);
    chk("d1_vld",    32'(digit_valid), 32'h03);

    // digit2: illegal pattern then blank
    digit_sel_n = 8'hFB;
    seg_n       = 7'h7E;
    step(5);
    chk("d2_err",       32'(digit_err), 32'h04);
    chk("d2_err_vld",   32'(digit_valid), 32'h03);
    chk("d2_err_val",   value, 32'h63);
    seg_n = 7'h7F;
    step(5);
    chk("d2_blank",     32'(digit_blank), 32'h04);
    chk("d2_blank_vld", 32'(digit_valid), 32'h07);
    chk("d2_blank_err", 32'(digit_err), 32'h0);
    chk("d2_blank_val", value, 32'h63);
    chk("fd_none_yet",  32'(fd_cnt), 32'h0);

    // scan digits 0..7 showing 1..8; frame completes on digit7's capture
    for (int d = 0; d < 8; d++) begin
      digit_sel_n = 8'(~(8'b1 << d));
      seg_n       = segtab[d];
      if (d == 7) begin
        fd0 = fd_cnt;
        step(4);
        chk("fd_before_d7", 32'(fd_cnt - fd0), 32'h0);
        step(1);
        chk("fd_on_d7_cap", 32'(frame_done), 32'h1);
        step(1);
        chk("fd_one_cycle", 32'(frame_done), 32'h0);
        chk("fd_total",     32'(fd_cnt), 32'h1);
      end else begin
        step(6);
      end
    end
    chk("scan_val",   value, 32'h87654321);
    chk("scan_vld",   32'(digit_valid), 32'hFF);
    chk("scan_blank", 32'(digit_blank), 32'h0);
    chk("scan_err",   32'(digit_err), 32'h0);

    // two selects low: invalid strobe, nothing changes
    digit_sel_n = 8'hFC;
    seg_n       = 7'h40;
    step(10);
    chk("multi_val", value, 32'h87654321);
    chk("multi_vld", 32'(digit_valid), 32'hFF);
    chk("multi_fd",  32'(fd_cnt), 32'h1);

    // clear lands on what would be digit0's capture edge
    digit_sel_n = 8'hFE;
    step(4);
    clear = 1'b1;
    step(1);
    chk("clr_val", value, 32'h0);
    chk("clr_vld", 32'(digit_valid), 32'h0);
    chk("clr_blk", 32'(digit_blank), 32'h0);
    chk("clr_err", 32'(digit_err), 32'h0);
    chk("clr_fd",  32'(frame_done), 32'h0);
    clear = 1'b0;

    // fresh capture on digit3 so reset has something to wipe
    digit_sel_n = 8'hF7;
    seg_n       = 7'h19;
    step(5);
    chk("d3_val", value, 32'h4000);
    chk("d3_vld", 32'(digit_valid), 32'h08);

    // reset two edges into a stable strobe on digit4
    digit_sel_n = 8'hEF;
    seg_n       = 7'h12;
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_val", value, 32'h0);
    chk("arst_vld", 32'(digit_valid), 32'h0);
    #2 rst = 1'b0;
    step(4);
    chk("post_rst_e4", value, 32'h0);
    step(1);
    chk("post_rst_e5_val", value, 32'h50000);
    chk("post_rst_e5_vld", 32'(digit_valid), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Monitors a time-multiplexed, active-low 7-segment display bus (digit selects plus segment lines) and recovers the hex nibble shown on each digit.
- Qualifies each digit strobe for stability before decoding, and flags blank and illegal patterns.
- Used in self-check and loopback paths to read display output back into registers for compare against the intended value.

Parameters:
- NDIGITS, 8, number of multiplexed digits (1..16).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- seg_n  input  7  segment lines, active-low; bit0=top, 1=upper-right, 2=lower-right, 3=bottom, 4=lower-left, 5=upper-left, 6=middle.
- digit_sel_n  input  NDIGITS  digit select, active-low, one-hot when valid.
- clear  input  1  synchronous clear of all captured state.
- value  output  4*NDIGITS  decoded nibbles; digit k occupies bits [4k+3:4k].
- digit_valid  output  NDIGITS  digit k holds a legal or blank capture.
- digit_blank  output  NDIGITS  last capture of digit k was all segments off.
- digit_err  output  NDIGITS  last capture of digit k was an illegal pattern.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; sample registers s_sel=all ones, s_seg=7'h7F; stability counter 0; seen mask 0.
- Every rising edge registers digit_sel_n and seg_n into s_sel and s_seg. All decoding works on the registered copies.
- Strobe valid: exactly one bit of s_sel is 0. Zero or multiple low bits means invalid.
- Stability counter, per edge:
  - new sample equals previous sample and strobe valid: increment, saturating at STABLE_CYCLES;
  - otherwise: 1 if strobe valid, else 0.
- FSM states:
  - IDLE: strobe invalid. Go to TRACK when a valid strobe is sampled.
  - TRACK: counting. Reaching STABLE_CYCLES performs a capture and goes to CAPTURED. Sample change: stay in TRACK with the counter restarted. Invalid strobe: go to IDLE.
  - CAPTURED: no further capture. Any sample change goes to TRACK (valid) or IDLE (invalid).
- Capture latency: outputs update on the rising edge where the counter reaches STABLE_CYCLES. That is the (STABLE_CYCLES+1)th consecutive rising edge with identical pin values, counting the first sampling edge.
- Decode table for s_seg (hex) -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
- Capture on digit k:
  - legal pattern: nibble k = decoded value; valid[k]=1, blank[k]=0, err[k]=0.
  - 7F: blank[k]=1, valid[k]=1, err[k]=0; nibble k unchanged.
  - any other pattern: err[k]=1, valid[k]=0, blank[k]=0; nibble k unchanged.
- Every capture (including err) sets seen[k].
- frame_done: if seen, including the current capture, becomes all ones, pulse frame_done for that cycle and clear seen on the same edge.
- clear: on the next edge zeroes value, valid, blank, err, seen and the counter, and forces IDLE. clear has priority over a capture in the same cycle, and frame_done stays 0 that cycle.
- Recapturing the same digit with a new value overwrites it. Re-strobing the same digit does not retrigger a capture unless the samples change in between.
- Reset mid-tracking: the partial count is discarded and no capture occurs.

Test Plan:
- select digit0 (digit_sel_n=8'hFE), seg_n=7'h30 held for 5 edges -> value[3:0]=3 and digit_valid[0]=1 on the 5th edge; both still 0 after the 4th.
- digit1 with seg_n=7'h12 for 3 edges, then 7'h02 for 5 edges -> value[7:4]=6, never 5; exactly one capture.
- digit2 with seg_n=7'h7E for 5 edges -> digit_err[2]=1, digit_valid[2]=0, value[11:8] unchanged; then 7'h7F -> digit_blank[2]=1, digit_valid[2]=1, err cleared.
- scan digits 0..7 showing 1..8, 6 edges each -> value=32'h87654321; frame_done high for exactly one cycle, on digit7's capture edge.
- digit_sel_n=8'hFC (two low) held for 10 edges -> no output change, FSM stays IDLE; assert clear on a capture edge -> all outputs 0, no frame_done.
- assert rst asynchronously 2 edges into a stable strobe -> outputs 0 immediately; after release, a capture needs the full 5 stable edges.
